// File: rtl/pkg_definitions.sv
// Shared types and defaults for the FIFO write-port arbiter.
package pkg_definitions;
  localparam int NREQ_DEF      = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int NBITS_DEF     = 32;

  typedef enum logic {IDLE, LOCK} arb_state_t;
  typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular first-one search: lowest-distance valid requester at or after rr_ptr.
module rr_pick
  import pkg_definitions::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  cand,
  output logic            any
);
  logic [IDW-1:0] pos;

  // Walk from farthest to nearest so the nearest valid index wins.
  always_comb begin
    cand = '0;
    any  = 1'b0;
    pos  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[pos]) begin
        cand = pos;
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for a single-clock FIFO write port.
// FIFO_WR_ARB_STATS_EN adds per-requester saturating transfer counters (grant_cnt).
module fifo_wr_arbiter
  import pkg_definitions::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int NBITS     = NBITS_DEF,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ-1:0][NBITS-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_wr_en,
  output logic [NBITS-1:0]           fifo_wr_data,
  input  logic                       fifo_full,
  input  logic                       fifo_almost_full,
  output logic [IDW-1:0]             grant_id,
  output logic                       locked
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]      grant_cnt
`endif
);
  arb_state_t     state;
  logic [IDW-1:0] rr_ptr, owner, cand, sel;
  logic [7:0]     cnt, cnt_nxt;
  logic           any, ok, xfer, release_now;

  function automatic logic [IDW-1:0] nxt_id(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .cand      (cand),
    .any       (any)
  );

  // almost_full closes the gate a beat early to cover the write held in the output register.
  assign ok = !fifo_full && !fifo_almost_full;

  always_comb begin
    sel       = (state == LOCK) ? owner : cand;
    req_ready = '0;
    if (!rst && ok && (state == LOCK || any)) req_ready[sel] = 1'b1;
  end

  assign xfer        = |(req_valid & req_ready);
  assign cnt_nxt     = (state == IDLE) ? 8'd1 : cnt + 8'd1;
  assign release_now = req_last[sel] || (cnt_nxt == 8'(MAX_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      cnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        fifo_wr_data <= req_data[sel];
        grant_id     <= sel;
        if (release_now) begin
          state  <= IDLE;
          locked <= 1'b0;
          cnt    <= '0;
          rr_ptr <= nxt_id(sel);
        end else begin
          state  <= LOCK;
          locked <= 1'b1;
          cnt    <= cnt_nxt;
          owner  <= sel;
        end
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_fifo_wr_arbiter;
  import pkg_definitions::*;

  localparam int NREQ = 4;
  localparam int MAXB = 4;
  localparam int NB   = NBITS_DEF;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid, req_last, req_ready;
  logic [NREQ-1:0][NB-1:0] req_data;
  logic                    fifo_wr_en;
  logic [NB-1:0]           fifo_wr_data;
  logic                    fifo_full, fifo_almost_full;
  req_id_t                 grant_id;
  logic                    locked;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ-1:0][15:0]   grant_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .NBITS(NB)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .locked           (locked)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .grant_cnt        (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [NB-1:0] data;
  } beat_t;

  beat_t         q[NREQ][$];
  int            glog[$], eg[$];
  logic [NB-1:0] dlog[$], ed[$];
  int            n_assert = 0, n_fail = 0;

  // Reference model: owner-or-rotating-priority arbitration in plain integers.
  bit            m_lock;
  int            m_owner, m_rr, m_cnt, m_gid;
  logic          m_wr_en;
  logic [NB-1:0] m_wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_gid = 0;
    m_wr_en = 1'b0; m_wr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    glog.delete(); dlog.delete();
  endtask

  // One clock: drive from the requester queues, check ready, advance model, check outputs.
  task automatic step();
    logic [NREQ-1:0] exp_rdy, acc;
    int sel;
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = 1'b1; req_last[i] = q[i][0].last; req_data[i] = q[i][0].data;
      end else begin
        req_valid[i] = 1'b0; req_last[i] = 1'($urandom); req_data[i] = NB'($urandom);
      end
    end
    exp_rdy = '0;
    sel = -1;
    if (!fifo_full && !fifo_almost_full) begin
      if (m_lock) sel = m_owner;
      else
        for (int k = 0; k < NREQ; k++)
          if (sel < 0 && req_valid[(m_rr + k) % NREQ]) sel = (m_rr + k) % NREQ;
      if (sel >= 0) exp_rdy[sel] = 1'b1;
    end
    #1;
    chk("req_ready", req_ready, exp_rdy);
    m_wr_en = 1'b0;
    if (sel >= 0 && req_valid[sel]) begin
      m_wr_en = 1'b1; m_wr_data = req_data[sel]; m_gid = sel;
      m_cnt = m_lock ? m_cnt + 1 : 1;
      if (req_last[sel] || m_cnt == MAXB) begin
        m_lock = 0; m_rr = (sel + 1) % NREQ;
      end else begin
        m_lock = 1; m_owner = sel;
      end
    end
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) begin glog.push_back(i); void'(q[i].pop_front()); end
    @(posedge clk); #1;
    chk("wr_en", fifo_wr_en, m_wr_en);
    chk("wr_data", fifo_wr_data, m_wr_data);
    chk("locked", locked, m_lock);
    chk("grant_id", grant_id, m_gid);
    if (fifo_wr_en) dlog.push_back(fifo_wr_data);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_ngrant"}, glog.size(), eg.size());
    for (int k = 0; k < eg.size(); k++)
      chk({tag, "_grant"}, (k < glog.size()) ? glog[k] : -1, eg[k]);
    chk({tag, "_nwrite"}, dlog.size(), ed.size());
    for (int k = 0; k < ed.size(); k++)
      chk({tag, "_data"}, (k < dlog.size()) ? dlog[k] : '1, ed[k]);
    glog.delete(); dlog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    req_valid = '1; req_last = '0; req_data = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_wr_data", fifo_wr_data, '0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_ready", req_ready, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat requesters 0 and 2 alternate with a continuous write stream.
    q[0].push_back({1'b1, NB'(32'h1000)}); q[0].push_back({1'b1, NB'(32'h1001)});
    q[2].push_back({1'b1, NB'(32'h2000)}); q[2].push_back({1'b1, NB'(32'h2001)});
    for (int s = 0; s < 4; s++) begin
      step();
      chk("t1_wr_cont", fifo_wr_en, 1'b1);
    end
    eg = '{0, 2, 0, 2};
    ed = '{NB'(32'h1000), NB'(32'h2000), NB'(32'h1001), NB'(32'h2001)};
    check_logs("t1");

    // 3-beat locked burst from 1 while 3 waits.
    do_reset();
    q[1].push_back({1'b0, NB'(32'hA)}); q[1].push_back({1'b0, NB'(32'hB)});
    q[1].push_back({1'b1, NB'(32'hC)}); q[3].push_back({1'b1, NB'(32'hD)});
    step(); chk("t2_locked_a", locked, 1'b1);
    step(); chk("t2_locked_b", locked, 1'b1);
    step(); chk("t2_locked_c", locked, 1'b0);
    step();
    eg = '{1, 1, 1, 3};
    ed = '{NB'(32'hA), NB'(32'hB), NB'(32'hC), NB'(32'hD)};
    check_logs("t2");

    // MAX_BURST forces release after 4 beats; requester 1 slips in.
    do_reset();
    for (int k = 0; k < 6; k++) q[0].push_back({k == 5, NB'(32'h300 + k)});
    q[1].push_back({1'b1, NB'(32'h310)});
    for (int s = 0; s < 7; s++) step();
    eg = '{0, 0, 0, 0, 1, 0, 0};
    ed = '{NB'(32'h300), NB'(32'h301), NB'(32'h302), NB'(32'h303),
           NB'(32'h310), NB'(32'h304), NB'(32'h305)};
    check_logs("t3");

    // almost_full throttles all requesters; full never sees a write.
    do_reset();
    for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, NB'(32'h400 + i)});
    step();
    fifo_almost_full = 1'b1;
    step(); chk("t4_ready_zero", req_ready, '0);
    fifo_full = 1'b1;
    step(); chk("t4_no_wr_full", fifo_wr_en, 1'b0);
    step(); chk("t4_no_wr_full", fifo_wr_en, 1'b0);
    fifo_full = 1'b0;
    step(); chk("t4_ready_zero", req_ready, '0);
    fifo_almost_full = 1'b0;
    for (int s = 0; s < 3; s++) step();
    eg = '{0, 1, 2, 3};
    ed = '{NB'(32'h400), NB'(32'h401), NB'(32'h402), NB'(32'h403)};
    check_logs("t4");

    // Reset mid-burst aborts the lock and restarts priority at 0.
    do_reset();
    q[2].push_back({1'b1, NB'(32'h520)});
    step();
    q[1].push_back({1'b0, NB'(32'h511)}); q[1].push_back({1'b0, NB'(32'h512)});
    q[1].push_back({1'b1, NB'(32'h513)});
    step();
    q[3].push_back({1'b1, NB'(32'h530)});
    step();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_wr_en", fifo_wr_en, 1'b0);
    chk("t5_rst_locked", locked, 1'b0);
    chk("t5_rst_ready", req_ready, '0);
    chk("t5_rst_grant", grant_id, '0);
    model_reset();
    @(posedge clk); #1;
    chk("t5_no_wr_in_rst", fifo_wr_en, 1'b0);
    rst = 1'b0;
    step(); step();
    eg = '{2, 1, 1, 1, 3};
    ed = '{NB'(32'h520), NB'(32'h511), NB'(32'h512), NB'(32'h513), NB'(32'h530)};
    check_logs("t5");

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) q[2].push_back({k == 4, NB'(32'h600 + k)});
    for (int s = 0; s < 5; s++) step();
    for (int i = 0; i < NREQ; i++) chk("t6_grant_cnt", grant_cnt[i], (i == 2) ? 5 : 0);
`endif

    // Random traffic and throttling against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 2) == 0 && q[i].size() < 4)
          q[i].push_back({$urandom_range(0, 2) == 0, NB'($urandom)});
      fifo_almost_full = ($urandom_range(0, 4) == 0);
      fifo_full        = fifo_almost_full && ($urandom_range(0, 1) == 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Shares the write port of one single-clock FIFO among `NREQ` requesters using round-robin arbitration with burst locking. It drives the FIFO's `wr_en`/`wr_data` from registers and throttles requesters using `full`/`almost_full`, so the FIFO can never be written while full. It sits directly upstream of the single-clock FIFO, in the same clock domain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 8: maximum beats per grant, 1..255.
- `NBITS`, from `pkg_definitions`: data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NREQ  requester i has a beat.
- `req_last`  in  NREQ  beat is the last of requester i's burst.
- `req_data`  in  NREQ x NBITS  requester i's beat data.
- `req_ready`  out  NREQ  beat of requester i is accepted this cycle.
- `fifo_wr_en`  out  1  FIFO write strobe, registered.
- `fifo_wr_data`  out  NBITS  FIFO write data, registered.
- `fifo_full`  in  1  FIFO full.
- `fifo_almost_full`  in  1  FIFO has at most one free entry.
- `grant_id`  out  $clog2(NREQ)  current or last owner.
- `locked`  out  1  a burst is in progress.

## Operation
- A beat transfers on requester i when `req_valid[i] && req_ready[i]`.
- At most one `req_ready` bit is high in any cycle.
- Accept gate `ok = !fifo_full && !fifo_almost_full`. With `ok` low, all `req_ready` bits are 0.
- State machine has two states, IDLE and LOCK.
- IDLE:
  - Candidate is the first i with `req_valid[i]`, searching circularly from `rr_ptr`.
  - If `ok` is high, `req_ready[candidate]` = 1 and `grant_id` takes the candidate.
  - On a transfer, the beat counter is set to 1.
  - If `req_last` is high or `MAX_BURST == 1`: stay in IDLE and set `rr_ptr` to candidate+1 (mod `NREQ`).
  - Otherwise: go to LOCK with `owner` = candidate.
- LOCK:
  - Only `owner` may receive `req_ready`, gated by `ok`.
  - While the owner's `req_valid` is low, the lock holds and other requesters wait.
  - Each transfer increments the beat counter.
  - On a transfer with `req_last` high, or with counter == `MAX_BURST`: return to IDLE and set `rr_ptr` to owner+1.
- Reaching `MAX_BURST` forces release even without `req_last`. The requester re-arbitrates for the rest of its burst.
- The beat counter is 8 bits wide; it is cleared in IDLE and never wraps.
- Output register: on a transfer, `fifo_wr_en` = 1 and `fifo_wr_data` = the beat on the next edge. Otherwise `fifo_wr_en` = 0 and `fifo_wr_data` holds its value.
- `locked` is 1 in LOCK.
- Reset values:
  - State IDLE, `rr_ptr` 0, counter 0.
  - `fifo_wr_en` 0, `fifo_wr_data` 0, `grant_id` 0, `locked` 0.
  - `req_ready` is all 0 while `rst` is high.
- Reset mid-burst aborts the lock immediately. No write is issued after reset assertion.

## Timing
- `req_ready` is combinational from `req_valid`, state, `rr_ptr`, `fifo_full` and `fifo_almost_full`. It does not depend on `req_data` or `req_last`.
- Latency: transfer at edge t → `fifo_wr_en` high during cycle t+1.
- Back-to-back transfers give a continuous `fifo_wr_en` stream, with no bubble on an owner change.
- Overflow safety: `almost_full` closes the gate one beat early. This covers the one write in flight in the output register.
- Throttle: `fifo_almost_full` rising at cycle t → no transfer at t. At most the one already-registered write lands.

## Configuration
- Macro `FIFO_WR_ARB_STATS_EN`.
- Defined: adds output `grant_cnt`, NREQ x 16 bits.
  - Entry i counts transfers of requester i and saturates at 16'hFFFF.
  - Entries are cleared by `rst`.
- Undefined: the port and counters are absent; all other behaviour is identical.

## Structure
- In `pkg_definitions`:
  - `NREQ` and `MAX_BURST` defaults.
  - Typedef `arb_state_t` enum {IDLE, LOCK}.
  - Typedef `req_id_t` logic [$clog2(NREQ)-1:0].
- Sub-module `rr_pick`: combinational circular first-one search. Inputs `req_valid` and `rr_ptr`; outputs candidate and `any`.
- Top level holds the FSM, beat counter, output register and optional stats.

## Test plan
- Requesters 0 and 2 valid, single-beat (`req_last`=1), FIFO empty → grants alternate 0,2,0,2; `fifo_wr_en` continuous from cycle 1.
- Requester 1 sends a 3-beat burst A,B,C while requester 3 is valid → `locked` high for the burst; FIFO receives A,B,C, then requester 3's beat.
- `MAX_BURST`=4, requester 0 sends 6 beats without `req_last` while requester 1 is valid → beats 0–3, then requester 1, then requester 0's remaining 2.
- `fifo_almost_full` asserted with all requesters valid → `req_ready` all 0 until it deasserts; `fifo_full` never sees a write.
- `rst` pulsed mid-burst → `fifo_wr_en` 0, `locked` 0, `rr_ptr` 0 immediately; the next grant goes to the lowest valid index.
- `FIFO_WR_ARB_STATS_EN` defined, 5 beats from requester 2 → `grant_cnt[2]` = 5, others 0.
